// File: rtl/wave_gen_pkg.sv
// Shared definitions for the waveform generator.
//   state_t  : FSM state codes; these are also the values driven on the phase port
//   MODE_*   : waveform shape selectors; MODE_TRAP_ALT is an alias for trapezoid
//   norm_mode: folds the alias onto MODE_TRAP so the datapath decodes three shapes
package wave_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RISE = 3'd1,
        ST_HIGH = 3'd2,
        ST_FALL = 3'd3,
        ST_LOW  = 3'd4
    } state_t;

    localparam logic [1:0] MODE_TRAP     = 2'd0;
    localparam logic [1:0] MODE_TRI      = 2'd1;
    localparam logic [1:0] MODE_SAW      = 2'd2;
    localparam logic [1:0] MODE_TRAP_ALT = 2'd3;

    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == MODE_TRAP_ALT) ? MODE_TRAP : m;
    endfunction

endpackage

// File: rtl/wave_hold_timer.sv
// Down-counter used to time the plateau (HIGH) and floor (LOW) dwell periods.
//   clk      : clock
//   res      : synchronous active-low reset
//   load     : load load_val (the first dwell cycle follows the load edge)
//   load_val : dwell length in cycles, must be non-zero when loaded
//   run      : high while the FSM sits in the dwell state
//   expire   : high on the last dwell cycle
module wave_hold_timer #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          res,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          run,
    output logic          expire
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!res) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (run && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
        end
    end

    // "<= 1" rather than "== 1" so a zero count can never trap the FSM.
    assign expire = run && (cnt <= CW'(1));

endmodule

// File: rtl/wave_gen_param.sv
// Periodic trapezoid / triangle / sawtooth generator.
//   clk      : clock
//   res      : synchronous active-low reset
//   en       : run request (level)
//   oneshot  : 1 = one period per enable edge, 0 = repeat while en
//   mode     : 0 trapezoid, 1 triangle, 2 sawtooth, 3 trapezoid
//   top      : peak value
//   step     : per-cycle slope, 0 behaves as 1
//   hold_hi  : plateau cycles (trapezoid only)
//   hold_lo  : floor cycles after the fall (not used by triangle)
//   d_out    : registered sample
//   phase    : current state code
//   busy     : state != IDLE
//   cyc_done : high on the last cycle of every period
// All configuration is captured into shadow registers only when a period
// starts, so a period always runs with one consistent set of settings.
module wave_gen_param
    import wave_gen_pkg::*;
#(
    parameter int DW = 9,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          res,
    input  logic          en,
    input  logic          oneshot,
    input  logic [1:0]    mode,
    input  logic [DW-1:0] top,
    input  logic [DW-1:0] step,
    input  logic [CW-1:0] hold_hi,
    input  logic [CW-1:0] hold_lo,
    output logic [DW-1:0] d_out,
    output logic [2:0]    phase,
    output logic          busy,
    output logic          cyc_done
);

    state_t        state, state_nx;
    logic [DW-1:0] d_nx;

    // shadow configuration
    logic [1:0]    sh_mode;
    logic [DW-1:0] sh_top;
    logic [DW-1:0] sh_step;
    logic [CW-1:0] sh_hold_hi;
    logic [CW-1:0] sh_hold_lo;
    logic          sh_oneshot;

    // set after a one-shot period ends with en still high; start is blocked
    // until en has been seen low
    logic          hold_off;

    logic          period_end;
    logic          shadow_load;
    logic          tmr_load;
    logic [CW-1:0] tmr_val;
    logic          tmr_run;
    logic          tmr_expire;

    logic [DW-1:0] eff_step;
    logic [DW:0]   sum;
    logic [DW-1:0] rise_val;
    logic [DW-1:0] fall_val;

    // ------------------------------------------------------------------
    // Saturating datapath. The add is one bit wider so a large step can
    // never wrap past top.
    // ------------------------------------------------------------------
    assign eff_step = (sh_step == '0) ? DW'(1) : sh_step;
    assign sum      = {1'b0, d_out} + {1'b0, eff_step};
    assign rise_val = (sum > {1'b0, sh_top}) ? sh_top : sum[DW-1:0];
    // sawtooth uses the fall state as its single-cycle drop to zero
    assign fall_val = ((sh_mode == MODE_SAW) || (d_out < eff_step)) ? '0 : (d_out - eff_step);

    // ------------------------------------------------------------------
    // Dwell timer shared by HIGH and LOW
    // ------------------------------------------------------------------
    assign tmr_run = (state == ST_HIGH) || (state == ST_LOW);

    wave_hold_timer #(.CW(CW)) u_hold (
        .clk      (clk),
        .res      (res),
        .load     (tmr_load),
        .load_val (tmr_val),
        .run      (tmr_run),
        .expire   (tmr_expire)
    );

    // ------------------------------------------------------------------
    // FSM state register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!res) begin
            state <= ST_IDLE;
            d_out <= '0;
        end else begin
            state <= state_nx;
            d_out <= d_nx;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state / datapath select
    // ------------------------------------------------------------------
    always_comb begin
        state_nx   = state;
        d_nx       = d_out;
        tmr_load   = 1'b0;
        tmr_val    = sh_hold_hi;
        period_end = 1'b0;

        unique case (state)
            ST_IDLE: begin
                d_nx = '0;
                if (en && !hold_off) begin
                    state_nx = ST_RISE;
                end
            end

            ST_RISE: begin
                d_nx = rise_val;
                if (rise_val == sh_top) begin
                    if ((sh_mode == MODE_TRAP) && (sh_hold_hi != '0)) begin
                        state_nx = ST_HIGH;
                        tmr_load = 1'b1;
                        tmr_val  = sh_hold_hi;
                    end else begin
                        state_nx = ST_FALL;
                    end
                end
            end

            ST_HIGH: begin
                if (tmr_expire) begin
                    state_nx = ST_FALL;
                end
            end

            ST_FALL: begin
                d_nx = fall_val;
                if (fall_val == '0) begin
                    if ((sh_mode != MODE_TRI) && (sh_hold_lo != '0)) begin
                        state_nx = ST_LOW;
                        tmr_load = 1'b1;
                        tmr_val  = sh_hold_lo;
                    end else begin
                        period_end = 1'b1;
                    end
                end
            end

            ST_LOW: begin
                d_nx = '0;
                if (tmr_expire) begin
                    period_end = 1'b1;
                end
            end

            default: begin
                state_nx = ST_IDLE;
                d_nx     = '0;
            end
        endcase

        if (period_end) begin
            state_nx = (en && !sh_oneshot) ? ST_RISE : ST_IDLE;
        end
    end

    // A new period starts either from IDLE or straight out of the last one.
    assign shadow_load = (state_nx == ST_RISE) && ((state == ST_IDLE) || period_end);

    always_ff @(posedge clk) begin
        if (!res) begin
            sh_mode    <= MODE_TRAP;
            sh_top     <= '0;
            sh_step    <= '0;
            sh_hold_hi <= '0;
            sh_hold_lo <= '0;
            sh_oneshot <= 1'b0;
        end else if (shadow_load) begin
            sh_mode    <= norm_mode(mode);
            sh_top     <= top;
            sh_step    <= step;
            sh_hold_hi <= hold_hi;
            sh_hold_lo <= hold_lo;
            sh_oneshot <= oneshot;
        end
    end

    always_ff @(posedge clk) begin
        if (!res) begin
            hold_off <= 1'b0;
        end else if (!en) begin
            hold_off <= 1'b0;
        end else if (period_end && sh_oneshot) begin
            hold_off <= 1'b1;
        end
    end

    assign phase    = state;
    assign busy     = (state != ST_IDLE);
    assign cyc_done = period_end;

endmodule

// File: tb/tb_wave_gen_param.sv
module tb_wave_gen_param;

    localparam int DW = 9;
    localparam int CW = 16;

    logic          clk;
    logic          res;
    logic          en;
    logic          oneshot;
    logic [1:0]    mode;
    logic [DW-1:0] top;
    logic [DW-1:0] step;
    logic [CW-1:0] hold_hi;
    logic [CW-1:0] hold_lo;
    logic [DW-1:0] d_out;
    logic [2:0]    phase;
    logic          busy;
    logic          cyc_done;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    wave_gen_param #(.DW(DW), .CW(CW)) dut (
        .clk      (clk),
        .res      (res),
        .en       (en),
        .oneshot  (oneshot),
        .mode     (mode),
        .top      (top),
        .step     (step),
        .hold_hi  (hold_hi),
        .hold_lo  (hold_lo),
        .d_out    (d_out),
        .phase    (phase),
        .busy     (busy),
        .cyc_done (cyc_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- inputs as seen by each rising edge ----------------
    logic          cap_res = 1'b0;
    logic          cap_en = 1'b0;
    logic          cap_os = 1'b0;
    logic [1:0]    cap_mode = 2'd0;
    logic [DW-1:0] cap_top = '0;
    logic [DW-1:0] cap_step = '0;
    logic [CW-1:0] cap_hh = '0;
    logic [CW-1:0] cap_hl = '0;

    always @(posedge clk) begin
        cap_res  <= res;
        cap_en   <= en;
        cap_os   <= oneshot;
        cap_mode <= mode;
        cap_top  <= top;
        cap_step <= step;
        cap_hh   <= hold_hi;
        cap_hl   <= hold_lo;
    end

    // ---------------- reference model ----------------
    // A period is expanded into the full list of samples it shows; the model
    // then just walks the list one entry per clock.
    int m_q[$];
    bit m_busy = 0;
    bit m_os = 0;
    bit m_hold = 0;

    task build_period(input int md, input int tp, input int st, input int hh, input int hl);
        int s, v;
        bit fin;
        m_q.delete();
        s = (st == 0) ? 1 : st;
        v = 0;
        m_q.push_back(0);
        fin = 0;
        while (!fin) begin
            v = (v + s > tp) ? tp : v + s;
            if (v == tp) fin = 1;
            else m_q.push_back(v);
        end
        if (md == 0 || md == 3) for (int k = 0; k < hh; k++) m_q.push_back(tp);
        m_q.push_back(tp);
        if (md != 2) begin
            v = tp;
            fin = 0;
            while (!fin) begin
                v = (v >= s) ? v - s : 0;
                if (v == 0) fin = 1;
                else m_q.push_back(v);
            end
        end
        if (md != 1) for (int k = 0; k < hl; k++) m_q.push_back(0);
    endtask

    task step_model();
        if (!cap_res) begin
            m_busy = 0;
            m_hold = 0;
            m_os   = 0;
            m_q.delete();
        end else begin
            if (m_busy) begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) begin
                    if (cap_en && !m_os) begin
                        build_period(cap_mode, cap_top, cap_step, cap_hh, cap_hl);
                        m_os = cap_os;
                    end else begin
                        m_busy = 0;
                        if (m_os) m_hold = 1;
                    end
                end
            end else if (cap_en && !m_hold) begin
                build_period(cap_mode, cap_top, cap_step, cap_hh, cap_hl);
                m_busy = 1;
                m_os   = cap_os;
            end
            if (!cap_en) m_hold = 0;
        end
    endtask

    initial begin
        int e_d;
        bit e_done;
        forever begin
            @(negedge clk);
            step_model();
            if (chk_on) begin
                e_d    = m_busy ? m_q[0] : 0;
                e_done = m_busy && (m_q.size() == 1);
                n_cmp++;
                if ((int'(d_out) != e_d) || (cyc_done != e_done) || (busy != m_busy)) begin
                    n_bad++;
                    $display("FAIL stream t=%0t: got d_out=%0d cyc_done=%0b busy=%0b, want d_out=%0d cyc_done=%0b busy=%0b",
                             $time, d_out, cyc_done, busy, e_d, e_done, m_busy);
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (cyc_done) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic set_cfg(input logic [1:0] md, input int tp, input int st, input int hh, input int hl);
        mode    = md;
        top     = DW'(tp);
        step    = DW'(st);
        hold_hi = CW'(hh);
        hold_lo = CW'(hl);
    endtask

    // ---------------- directed period table ----------------
    typedef struct {
        logic [1:0] md;
        int tp;
        int st;
        int hh;
        int hl;
        int exp_period;
        int exp_peak;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl[NV];

    initial begin
        bit ok;
        int cnt, pk, dcnt, hcnt;
        int seq_exp[12];

        tbl[0] = '{2'd0, 10,  1,   4, 3, 27,  10};
        tbl[1] = '{2'd1, 299, 7,   0, 0, 86,  299};
        tbl[2] = '{2'd2, 8,   3,   0, 2, 6,   8};
        tbl[3] = '{2'd3, 5,   1,   2, 1, 13,  5};
        tbl[4] = '{2'd0, 6,   0,   0, 0, 12,  6};
        tbl[5] = '{2'd1, 0,   5,   0, 0, 2,   0};
        tbl[6] = '{2'd2, 511, 200, 3, 0, 4,   511};
        tbl[7] = '{2'd1, 10,  4,   5, 5, 6,   10};
        tbl[8] = '{2'd0, 3,   1,   0, 2, 8,   3};
        seq_exp = '{0, 3, 6, 8, 0, 0, 0, 3, 6, 8, 0, 0};

        res = 1'b0;
        en = 1'b0;
        oneshot = 1'b0;
        set_cfg(2'd0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset_d_out", d_out, 0);
        check("reset_phase", phase, 0);
        check("reset_busy", busy, 0);
        check("reset_cyc_done", cyc_done, 0);
        chk_on = 1;
        res = 1'b1;
        @(negedge clk);

        // start latency: one edge from en to RISE
        set_cfg(2'd0, 10, 1, 4, 3);
        en = 1'b1;
        @(negedge clk);
        check("start_phase", phase, 1);
        check("start_d_out", d_out, 0);
        @(negedge clk);
        check("first_inc", d_out, 1);
        en = 1'b0;
        wait_idle(200, ok);
        check("start_idle", ok, 1);

        for (int i = 0; i < NV; i++) begin
            set_cfg(tbl[i].md, tbl[i].tp, tbl[i].st, tbl[i].hh, tbl[i].hl);
            oneshot = 1'b0;
            en = 1'b1;
            wait_done(3000, ok);
            check($sformatf("tbl%0d_first_done", i), ok, 1);
            cnt = 0;
            pk = 0;
            for (int c = 0; c < 3000; c++) begin
                @(negedge clk);
                cnt++;
                if (int'(d_out) > pk) pk = d_out;
                if (cyc_done) break;
            end
            check($sformatf("tbl%0d_period", i), cnt, tbl[i].exp_period);
            check($sformatf("tbl%0d_peak", i), pk, tbl[i].exp_peak);
            en = 1'b0;
            wait_idle(3000, ok);
            check($sformatf("tbl%0d_idle", i), ok, 1);
        end

        // reset in the middle of a rise
        set_cfg(2'd1, 299, 1, 0, 0);
        en = 1'b1;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (d_out == 9'd57) begin
                ok = 1;
                break;
            end
        end
        check("mid_reset_reach57", ok, 1);
        check("mid_reset_phase_before", phase, 1);
        res = 1'b0;
        en = 1'b0;
        @(negedge clk);
        check("mid_reset_d_out", d_out, 0);
        check("mid_reset_phase", phase, 0);
        check("mid_reset_cyc_done", cyc_done, 0);
        res = 1'b1;
        @(negedge clk);

        // sawtooth sample sequence
        set_cfg(2'd2, 8, 3, 0, 2);
        en = 1'b1;
        wait_done(100, ok);
        check("saw_first_done", ok, 1);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check($sformatf("saw_seq%0d", i), d_out, seq_exp[i]);
        end
        en = 1'b0;
        wait_idle(100, ok);
        check("saw_idle", ok, 1);

        // trapezoid plateau length and done rate over two periods
        set_cfg(2'd0, 10, 1, 4, 3);
        en = 1'b1;
        wait_done(100, ok);
        check("trap_first_done", ok, 1);
        dcnt = 0;
        hcnt = 0;
        for (int i = 0; i < 54; i++) begin
            @(negedge clk);
            if (cyc_done) dcnt++;
            if (phase == 3'd2 && d_out == 9'd10) hcnt++;
        end
        check("trap_done_count", dcnt, 2);
        check("trap_high_cycles", hcnt, 8);
        check("trap_done_last", cyc_done, 1);
        en = 1'b0;
        wait_idle(100, ok);
        check("trap_idle", ok, 1);

        // one-shot with en held high, then re-armed by an en low pulse
        set_cfg(2'd1, 5, 1, 0, 0);
        oneshot = 1'b1;
        en = 1'b1;
        for (int r = 0; r < 2; r++) begin
            dcnt = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clk);
                if (cyc_done) dcnt++;
            end
            check($sformatf("oneshot%0d_done_count", r), dcnt, 1);
            check($sformatf("oneshot%0d_idle", r), busy, 0);
            en = 1'b0;
            @(negedge clk);
            en = 1'b1;
        end
        en = 1'b0;
        oneshot = 1'b0;
        @(negedge clk);

        // reprogram top mid-period and drop en; then restart with step 0
        set_cfg(2'd0, 10, 1, 2, 2);
        en = 1'b1;
        repeat (5) @(negedge clk);
        top = 9'd20;
        en = 1'b0;
        pk = 0;
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (int'(d_out) > pk) pk = d_out;
            if (!busy) begin
                ok = 1;
                break;
            end
        end
        check("reprog_finish", ok, 1);
        check("reprog_old_peak", pk, 10);
        step = 9'd0;
        en = 1'b1;
        cnt = 0;
        pk = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            cnt++;
            if (int'(d_out) > pk) pk = d_out;
            if (cyc_done) break;
        end
        check("reprog_new_period", cnt, 44);
        check("reprog_new_peak", pk, 20);
        en = 1'b0;
        wait_idle(200, ok);
        check("reprog_idle", ok, 1);

        // randomized configuration churn, checked by the model stream
        for (int it = 0; it < 30; it++) begin
            set_cfg(2'($urandom_range(0, 3)),
                    ($urandom_range(0, 4) == 0) ? $urandom_range(0, 511) : $urandom_range(0, 40),
                    $urandom_range(0, 7), $urandom_range(0, 4), $urandom_range(0, 4));
            oneshot = ($urandom_range(0, 3) == 0);
            en = ($urandom_range(0, 4) != 0);
            repeat ($urandom_range(10, 80)) @(negedge clk);
        end
        en = 1'b0;
        wait_idle(3000, ok);
        check("random_idle", ok, 1);
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
